ahb_slave_mem: RTL and testbench
================================

Name: ahb_slave_mem

Overview:
- AHB-Lite responder (subordinate) with a word-organised internal memory; the far end of the testbench AHB master interface.
- Sits on the AHB bus after the decoder (hsel) and the master; provides OKAY/ERROR responses, optional wait-state insertion, byte-lane writes, and read-after-write forwarding.
- Acts as the bus-functional target for master-side verification.

Parameters:
- ADDR_WIDTH, 32, haddr width.
- DATA_WIDTH, 32, hwdata/hrdata width; legal values 32 or 64.
- MEM_DEPTH, 256, memory size in DATA_WIDTH words; must be a power of 2.
- WAIT_CYCLES, 0, wait states per accepted transfer; used only with AHB_SLV_WAIT_EN.

Ports:
- clk  in  1  bus clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- hsel  in  1  slave select.
- haddr  in  ADDR_WIDTH  byte address.
- htrans  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- hwrite  in  1  1 = write.
- hsize  in  3  log2 bytes per beat.
- hburst  in  3  burst type; accepted, not checked.
- hprot  in  4  protection; accepted, ignored.
- hwdata  in  DATA_WIDTH  write data (data phase).
- hwstrb  in  DATA_WIDTH/8  byte strobes (data phase).
- hready  in  1  bus-level ready (mux output).
- hreadyout  out  1  slave ready.
- hresp  out  1  0 OKAY, 1 ERROR.
- hrdata  out  DATA_WIDTH  read data.

Behaviour:
- Reset: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, pending write cleared. Memory contents are not reset. Reset mid-transfer aborts the transfer; any pending write is discarded.
- Accept (address phase): hsel & hready & htrans[1]. Control is registered into data-phase registers on that edge. IDLE/BUSY, or hsel=0, yields an OKAY zero-wait data phase.
- Error check at accept; any one condition gives ERROR:
  - haddr >= MEM_DEPTH*DATA_WIDTH/8.
  - haddr not aligned to 2^hsize.
  - 2^hsize > DATA_WIDTH/8.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: a good accept goes to WAIT if WAIT_CYCLES>0, otherwise stays in IDLE with a zero-wait data phase. A bad accept goes to ERR1.
  - WAIT: hreadyout=0; counter counts down from WAIT_CYCLES. When the counter reaches 0, hreadyout=1 (final data cycle) and the FSM returns to IDLE, or re-enters WAIT/ERR1 on a pipelined accept in that cycle.
  - ERR1: hreadyout=0, hresp=1 (first cycle of the two-cycle error response).
  - ERR2: hreadyout=1, hresp=1. Next state follows the same accept rules as IDLE.
- Write:
  - Commit on the final data cycle (hreadyout=1, OKAY) at the rising edge.
  - Byte lane i is written when hwstrb[i] & lanemask[i]. lanemask is derived from hsize and haddr low bits.
  - ERROR transfers never write.
- Read:
  - hrdata is registered and loaded at the edge that ends the final wait cycle (the accept edge when zero-wait).
  - hrdata holds the full aligned word; it is 0 during IDLE/BUSY and ERROR data phases.
- Forwarding: a read accepted in the same cycle a write to the same word commits returns the merged (post-write) word.
- Back-to-back transfers are fully pipelined: an address phase overlaps the previous data phase. With zero waits, throughput is 1 beat per cycle.
- Memory word index = haddr[log2(MEM_DEPTH*DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)].

Optional Feature:
- Macro AHB_SLV_WAIT_EN.
- Defined: WAIT_CYCLES wait states are inserted on every good NONSEQ/SEQ transfer; a 5-bit down-counter is used.
- Undefined: WAIT_CYCLES is ignored, the WAIT state is not synthesised, and all OKAY transfers are zero-wait. Error responses remain two cycles.

Test Plan:
- Zero-wait write, then read: NONSEQ write word 0x10 = 0xDEADBEEF with hwstrb=0xF, then NONSEQ read 0x10 in the next cycle → hrdata=0xDEADBEEF, hresp=0 throughout, hreadyout never low.
- Byte write forwarding: mem[0x20]=0x11223344; byte write hsize=0 at 0x21, hwdata=0x0000AA00, hwstrb=0x2, with a pipelined read of 0x20 accepted during that data phase → read returns 0x1122AA44.
- Errors:
  - Misaligned halfword (hsize=1, haddr=0x3) → ERR1: hreadyout=0, hresp=1; ERR2: hreadyout=1, hresp=1; memory unchanged.
  - Out-of-range address 0x400 (MEM_DEPTH=256) → same two-cycle ERROR response.
- Wait states (AHB_SLV_WAIT_EN, WAIT_CYCLES=2): INCR4 read burst at 0x0 → each beat has exactly 2 cycles of hreadyout=0; data is correct for 0x0/0x4/0x8/0xC.
- IDLE/BUSY inside a burst: htrans=BUSY between SEQ beats → OKAY zero-wait, no memory access, hrdata=0.
- Reset mid-transfer: assert rst during the WAIT of a write → next cycle hreadyout=1, hresp=0, hrdata=0; the target word keeps its old value.

Source files
------------

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle between a master (or bench) and the ahb_slave_mem responder.
interface ahb_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    hsel;
    logic [ADDR_WIDTH-1:0]   haddr;
    logic [1:0]              htrans;
    logic                    hwrite;
    logic [2:0]              hsize;
    logic [2:0]              hburst;
    logic [3:0]              hprot;
    logic [DATA_WIDTH-1:0]   hwdata;
    logic [DATA_WIDTH/8-1:0] hwstrb;
    logic                    hready;
    logic                    hreadyout;
    logic                    hresp;
    logic [DATA_WIDTH-1:0]   hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot,
        output hwdata, hwstrb, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot,
        input  hwdata, hwstrb, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory responder: zero-wait pipelined OKAY beats, two-cycle ERROR, byte-lane writes with forwarding.
// Wait states (WAIT_CYCLES per good beat, hreadyout low) exist only when AHB_SLV_WAIT_EN is defined.
module ahb_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic           clk,
    input  logic           rst,
    ahb_slave_mem_if.slave bus
);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam int IDXW = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * NB);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_t                state;
    logic                  hreadyout_r;
    logic                  hresp_r;
    logic [DATA_WIDTH-1:0] hrdata_r;

    logic                  dp_vld;
    logic                  dp_write;
    logic [IDXW-1:0]       dp_idx;
    logic [NB-1:0]         dp_mask;

    logic [IDXW-1:0]       a_idx;
    logic [OFFW-1:0]       a_off;
    logic [NB-1:0]         a_mask;
    logic [ADDR_WIDTH-1:0] align_mask;
    logic                  a_err;
    logic                  can_acc;
    logic                  acc;
    logic                  commit;
    logic [NB-1:0]         wr_en;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] fwd_word;
    logic                  cnt_zero;

`ifdef AHB_SLV_WAIT_EN
    logic [4:0] cnt;
    assign cnt_zero = (cnt == 5'd0);
`else
    logic [4:0] unused_wait;
    assign unused_wait = 5'(WAIT_CYCLES);
    assign cnt_zero    = 1'b1;
`endif

    assign a_idx = bus.haddr[IDXW+OFFW-1:OFFW];
    assign a_off = bus.haddr[OFFW-1:0];

    always_comb begin
        a_mask = '0;
        for (int i = 0; i < NB; i++) begin
            a_mask[i] = (i >= int'(a_off)) && (i < int'(a_off) + (1 << bus.hsize));
        end
        align_mask = (ADDR_WIDTH'(1) << bus.hsize) - ADDR_WIDTH'(1);
        a_err = ({1'b0, bus.haddr} >= MEM_BYTES)
             || ((bus.haddr & align_mask) != '0)
             || (bus.hsize > 3'(OFFW));
    end

    // Beats can only start when the previous data phase is in its final (ready) cycle.
    assign can_acc = (state == ST_IDLE) || (state == ST_ERR2) || ((state == ST_WAIT) && cnt_zero);
    assign acc     = can_acc && bus.hsel && bus.hready && bus.htrans[1];
    assign commit  = dp_vld && dp_write && hreadyout_r
                  && ((state == ST_IDLE) || ((state == ST_WAIT) && cnt_zero));

    always_comb begin
        merged_word = mem[dp_idx];
        for (int i = 0; i < NB; i++) begin
            wr_en[i] = bus.hwstrb[i] && dp_mask[i];
            if (wr_en[i]) begin
                merged_word[8*i +: 8] = bus.hwdata[8*i +: 8];
            end
        end
        fwd_word = (commit && (dp_idx == a_idx)) ? merged_word : mem[a_idx];
    end

    always_ff @(posedge clk) begin
        if (commit && !rst) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_en[i]) begin
                    mem[dp_idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
            hrdata_r    <= '0;
            dp_vld      <= 1'b0;
            dp_write    <= 1'b0;
            dp_idx      <= '0;
            dp_mask     <= '0;
`ifdef AHB_SLV_WAIT_EN
            cnt         <= 5'd0;
`endif
        end else begin
            hrdata_r <= '0;
            if (state == ST_ERR1) begin
                state       <= ST_ERR2;
                hreadyout_r <= 1'b1;
                hresp_r     <= 1'b1;
`ifdef AHB_SLV_WAIT_EN
            end else if ((state == ST_WAIT) && !cnt_zero) begin
                cnt <= cnt - 5'd1;
                if (cnt == 5'd1) begin
                    hreadyout_r <= 1'b1;
                    if (!dp_write) begin
                        hrdata_r <= mem[dp_idx];
                    end
                end
`endif
            end else begin
                dp_vld   <= acc && !a_err;
                dp_write <= bus.hwrite;
                dp_idx   <= a_idx;
                dp_mask  <= a_mask;
                if (acc && a_err) begin
                    state       <= ST_ERR1;
                    hreadyout_r <= 1'b0;
                    hresp_r     <= 1'b1;
`ifdef AHB_SLV_WAIT_EN
                end else if (acc && (WAIT_CYCLES != 0)) begin
                    state       <= ST_WAIT;
                    cnt         <= 5'(WAIT_CYCLES);
                    hreadyout_r <= 1'b0;
                    hresp_r     <= 1'b0;
`endif
                end else begin
                    state       <= ST_IDLE;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= 1'b0;
                    if (acc && !bus.hwrite) begin
                        hrdata_r <= fwd_word;
                    end
                end
            end
        end
    end

    assign bus.hreadyout = hreadyout_r;
    assign bus.hresp     = hresp_r;
    assign bus.hrdata    = hrdata_r;

    logic unused_ok;
    assign unused_ok = ^{bus.hburst, bus.hprot, bus.htrans[0], bus.haddr[ADDR_WIDTH-1:IDXW+OFFW]};
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: pipelined AHB-Lite master driver, byte-array reference model, per-scenario tasks.
module tb_ahb_slave_mem;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DEPTH = 256;
    localparam int WC = 2;
`ifdef AHB_SLV_WAIT_EN
    localparam int WS = WC;
`else
    localparam int WS = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ahb_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
    assign bus.hready = bus.hreadyout;

    ahb_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  burst;
    } beat_t;

    typedef struct {
        int          waits;
        logic        resp_wait;
        logic        resp;
        logic [31:0] rdata;
    } res_t;

    logic [7:0] mem_m [0:DEPTH*4-1];
    beat_t bq[$];
    res_t  eq[$];
    res_t  rq[$];
    bit    tmo;
    int    n_tests = 0;
    int    n_fail = 0;

    // Sequential (one beat at a time) view of the slave's behaviour.
    function automatic res_t model_exec(beat_t b);
        res_t r;
        int nb, off, base;
        bit err;
        r.waits = 0; r.resp_wait = 1'b0; r.resp = 1'b0; r.rdata = '0;
        if (!b.sel || !b.trans[1]) return r;
        nb   = 1 << b.size;
        off  = int'(b.addr % 4);
        base = int'(b.addr) - off;
        err  = (b.addr >= 32'(DEPTH*4)) || ((b.addr % 32'(nb)) != 0) || (nb > 4);
        if (err) begin
            r.waits = 1; r.resp_wait = 1'b1; r.resp = 1'b1;
            return r;
        end
        r.waits = WS;
        if (b.wr) begin
            for (int i = 0; i < 4; i++)
                if (b.strb[i] && i >= off && i < off + nb) mem_m[base+i] = b.wdata[8*i +: 8];
        end else begin
            r.rdata = {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
        end
        return r;
    endfunction

    function automatic beat_t mk(logic sel, logic [1:0] trans, logic wr, logic [2:0] size,
                                 logic [31:0] addr, logic [31:0] wdata, logic [3:0] strb, logic [2:0] burst);
        beat_t b;
        b.sel = sel; b.trans = trans; b.wr = wr; b.size = size;
        b.addr = addr; b.wdata = wdata; b.strb = strb; b.burst = burst;
        return b;
    endfunction

    function automatic void add_beat(beat_t b);
        bq.push_back(b);
        eq.push_back(model_exec(b));
    endfunction

    task automatic drive_idle();
        bus.hsel = 1'b0; bus.haddr = '0; bus.htrans = 2'b00; bus.hwrite = 1'b0;
        bus.hsize = 3'd2; bus.hburst = 3'd0; bus.hprot = 4'h3;
        bus.hwdata = '0; bus.hwstrb = '0;
    endtask

    // Runs bq through the pipelined bus; called and returns just after a rising edge.
    task automatic run_bus();
        int idx, dp, cyc;
        res_t blank;
        logic rdy;
        blank.waits = 0; blank.resp_wait = 1'b0; blank.resp = 1'bx; blank.rdata = 'x;
        rq.delete();
        foreach (bq[i]) rq.push_back(blank);
        idx = 0; dp = -1; cyc = 0; tmo = 1'b0;
        while ((idx < bq.size() || dp >= 0) && cyc < 2000) begin
            if (idx < bq.size()) begin
                bus.hsel = bq[idx].sel; bus.htrans = bq[idx].trans; bus.hwrite = bq[idx].wr;
                bus.hsize = bq[idx].size; bus.haddr = bq[idx].addr; bus.hburst = bq[idx].burst;
            end else begin
                bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwrite = 1'b0;
            end
            if (dp >= 0 && bq[dp].wr) begin
                bus.hwdata = bq[dp].wdata; bus.hwstrb = bq[dp].strb;
            end else begin
                bus.hwdata = '0; bus.hwstrb = '0;
            end
            rdy = bus.hreadyout;
            if (dp >= 0) begin
                if (rdy !== 1'b1) begin
                    rq[dp].waits = rq[dp].waits + 1;
                    if (bus.hresp === 1'b1) rq[dp].resp_wait = 1'b1;
                end else begin
                    rq[dp].resp = bus.hresp;
                    rq[dp].rdata = bus.hrdata;
                    dp = -1;
                end
            end
            if (rdy === 1'b1 && idx < bq.size()) begin
                dp = idx;
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 2000) tmo = 1'b1;
        drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_tests++; if (bus.hreadyout !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout got=%b exp=1", bus.hreadyout); end
        n_tests++; if (bus.hresp !== 1'b0) begin n_fail++; $display("FAIL reset_hresp got=%b exp=0", bus.hresp); end
        n_tests++; if (bus.hrdata !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata got=%h exp=0", bus.hrdata); end
    endtask

    task automatic test_fill();
        bq.delete(); eq.delete();
        for (int w = 0; w < DEPTH; w++)
            add_beat(mk(1'b1, (w == 0) ? 2'b10 : 2'b11, 1'b1, 3'd2, 32'(w*4), $urandom, 4'hF, 3'd1));
        run_bus();
        n_tests++; if (tmo) begin n_fail++; $display("FAIL fill_timeout got=expired exp=done"); end
    endtask

    task automatic test_write_read();
        bq.delete(); eq.delete();
        add_beat(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0));
        add_beat(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0, 4'h0, 3'd0));
        run_bus();
        n_tests++; if (tmo) begin n_fail++; $display("FAIL wr_rd_timeout got=expired exp=done"); end
        n_tests++; if (rq[1].rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_data got=%h exp=deadbeef", rq[1].rdata); end
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (rq[i].resp !== 1'b0 || rq[i].resp_wait !== 1'b0 || rq[i].waits !== WS) begin
                n_fail++; $display("FAIL wr_rd_resp beat%0d got resp=%b waits=%0d exp resp=0 waits=%0d", i, rq[i].resp, rq[i].waits, WS);
            end
        end
    endtask

    task automatic test_byte_forward();
        bq.delete(); eq.delete();
        add_beat(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h20, 32'h11223344, 4'hF, 3'd0));
        add_beat(mk(1'b1, 2'b10, 1'b1, 3'd0, 32'h21, 32'h0000AA00, 4'h2, 3'd0));
        add_beat(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 32'h0, 4'h0, 3'd0));
        run_bus();
        n_tests++; if (tmo) begin n_fail++; $display("FAIL fwd_timeout got=expired exp=done"); end
        n_tests++; if (rq[2].rdata !== 32'h1122AA44) begin n_fail++; $display("FAIL fwd_data got=%h exp=1122aa44", rq[2].rdata); end
        n_tests++; if (rq[2].resp !== 1'b0 || rq[2].waits !== WS) begin n_fail++; $display("FAIL fwd_resp got resp=%b waits=%0d exp 0/%0d", rq[2].resp, rq[2].waits, WS); end
    endtask

    task automatic test_errors();
        bq.delete(); eq.delete();
        add_beat(mk(1'b1, 2'b10, 1'b1, 3'd1, 32'h3, 32'hFFFFFFFF, 4'hF, 3'd0));
        add_beat(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h400, 32'hFFFFFFFF, 4'hF, 3'd0));
        add_beat(mk(1'b1, 2'b10, 1'b0, 3'd3, 32'h8, 32'h0, 4'h0, 3'd0));
        add_beat(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h0, 32'h0, 4'h0, 3'd0));
        add_beat(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h8, 32'h0, 4'h0, 3'd0));
        run_bus();
        n_tests++; if (tmo) begin n_fail++; $display("FAIL err_timeout got=expired exp=done"); end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (rq[i].waits !== 1 || rq[i].resp_wait !== 1'b1) begin
                n_fail++; $display("FAIL err_first beat%0d got low=%0d resp=%b exp low=1 resp=1", i, rq[i].waits, rq[i].resp_wait);
            end
            n_tests++;
            if (rq[i].resp !== 1'b1) begin n_fail++; $display("FAIL err_second beat%0d got resp=%b exp=1", i, rq[i].resp); end
        end
        for (int i = 3; i < 5; i++) begin
            n_tests++;
            if (rq[i].rdata !== eq[i].rdata || rq[i].resp !== 1'b0) begin
                n_fail++; $display("FAIL err_mem_kept beat%0d got=%h/%b exp=%h/0", i, rq[i].rdata, rq[i].resp, eq[i].rdata);
            end
        end
    endtask

    task automatic test_burst();
        bq.delete(); eq.delete();
        for (int i = 0; i < 4; i++)
            add_beat(mk(1'b1, (i == 0) ? 2'b10 : 2'b11, 1'b0, 3'd2, 32'(i*4), 32'h0, 4'h0, 3'd3));
        run_bus();
        n_tests++; if (tmo) begin n_fail++; $display("FAIL burst_timeout got=expired exp=done"); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rq[i].waits !== WS) begin n_fail++; $display("FAIL burst_waits beat%0d got=%0d exp=%0d", i, rq[i].waits, WS); end
            n_tests++;
            if (rq[i].rdata !== eq[i].rdata || rq[i].resp !== 1'b0) begin
                n_fail++; $display("FAIL burst_data beat%0d got=%h/%b exp=%h/0", i, rq[i].rdata, rq[i].resp, eq[i].rdata);
            end
        end
    endtask

    task automatic test_busy();
        bq.delete(); eq.delete();
        add_beat(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h40, 32'h0, 4'h0, 3'd1));
        add_beat(mk(1'b1, 2'b01, 1'b1, 3'd2, 32'h44, 32'hFFFFFFFF, 4'hF, 3'd1));
        add_beat(mk(1'b1, 2'b11, 1'b0, 3'd2, 32'h44, 32'h0, 4'h0, 3'd1));
        run_bus();
        n_tests++; if (tmo) begin n_fail++; $display("FAIL busy_timeout got=expired exp=done"); end
        n_tests++;
        if (rq[1].rdata !== 32'h0 || rq[1].resp !== 1'b0 || rq[1].waits !== 0) begin
            n_fail++; $display("FAIL busy_beat got data=%h resp=%b waits=%0d exp 0/0/0", rq[1].rdata, rq[1].resp, rq[1].waits);
        end
        n_tests++;
        if (rq[2].rdata !== eq[2].rdata) begin n_fail++; $display("FAIL busy_no_write got=%h exp=%h", rq[2].rdata, eq[2].rdata); end
    endtask

    task automatic test_back_to_back();
        beat_t b;
        int r;
        bq.delete(); eq.delete();
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 11);
            b.sel = (r != 2); b.trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'(2 + $urandom_range(0, 1));
            b.wr = 1'($urandom_range(0, 1)); b.size = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 11) == 0) b.size = 3'd3;
            b.addr = 32'($urandom_range(0, 1023)) & ~((32'd1 << b.size) - 32'd1);
            if (r == 3 && b.size != 0) b.addr = b.addr | 32'd1;
            if (r == 4) b.addr = 32'(1024 + $urandom_range(0, 255) * 4);
            b.wdata = $urandom; b.strb = 4'($urandom_range(0, 15)); b.burst = 3'd1;
            add_beat(b);
        end
        run_bus();
        n_tests++; if (tmo) begin n_fail++; $display("FAIL b2b_timeout got=expired exp=done"); end
        for (int i = 0; i < bq.size(); i++) begin
            n_tests++;
            if (rq[i].waits !== eq[i].waits || rq[i].resp_wait !== eq[i].resp_wait) begin
                n_fail++; $display("FAIL b2b_waits beat%0d got=%0d/%b exp=%0d/%b", i, rq[i].waits, rq[i].resp_wait, eq[i].waits, eq[i].resp_wait);
            end
            n_tests++;
            if (rq[i].resp !== eq[i].resp || rq[i].rdata !== eq[i].rdata) begin
                n_fail++; $display("FAIL b2b_data beat%0d addr=%h got=%h/%b exp=%h/%b", i, bq[i].addr, rq[i].rdata, rq[i].resp, eq[i].rdata, eq[i].resp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] old;
        old = {mem_m[8'h83], mem_m[8'h82], mem_m[8'h81], mem_m[8'h80]};
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.hwrite = 1'b1; bus.hsize = 3'd2; bus.haddr = 32'h80;
        @(posedge clk); #1;
        drive_idle();
        bus.hwdata = ~old; bus.hwstrb = 4'hF; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.hwdata = '0; bus.hwstrb = '0;
        n_tests++; if (bus.hreadyout !== 1'b1) begin n_fail++; $display("FAIL rstmid_hreadyout got=%b exp=1", bus.hreadyout); end
        n_tests++; if (bus.hresp !== 1'b0) begin n_fail++; $display("FAIL rstmid_hresp got=%b exp=0", bus.hresp); end
        n_tests++; if (bus.hrdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_hrdata got=%h exp=0", bus.hrdata); end
        bq.delete(); eq.delete();
        add_beat(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h80, 32'h0, 4'h0, 3'd0));
        run_bus();
        n_tests++; if (tmo) begin n_fail++; $display("FAIL rstmid_timeout got=expired exp=done"); end
        n_tests++; if (rq[0].rdata !== old) begin n_fail++; $display("FAIL rstmid_kept got=%h exp=%h", rq[0].rdata, old); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_byte_forward();
        test_errors();
        test_burst();
        test_busy();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
